// File: rtl/dtw_pkg.sv
// Shared DTW definitions: path-direction codes (also used by the PE array),
// the traceback FSM state encoding and the default coordinate width.
package dtw_pkg;

  localparam int IDX_W = 5;

  localparam logic [1:0] PATH_DIAG = 2'b11;
  localparam logic [1:0] PATH_UP   = 2'b10;
  localparam logic [1:0] PATH_LEFT = 2'b01;
  localparam logic [1:0] PATH_RST  = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_WAIT = 3'd2,
    S_EMIT = 3'd3,
    S_FIN  = 3'd4
  } dtw_state_e;

endpackage

// File: rtl/dtw_tb_step.sv
// One traceback step: decodes a path code at (cur_i, cur_j) into the previous
// cell and flags codes that are invalid or would step off the grid edge.
module dtw_tb_step #(
  parameter int IDX_W = dtw_pkg::IDX_W
) (
  input  logic [1:0]       i_code,
  input  logic [IDX_W-1:0] i_cur_i,
  input  logic [IDX_W-1:0] i_cur_j,
  output logic [IDX_W-1:0] o_next_i,
  output logic [IDX_W-1:0] o_next_j,
  output logic             o_illegal
);
  import dtw_pkg::*;

  localparam logic [IDX_W-1:0] ONE = IDX_W'(1);

  logic w_i_zero;
  logic w_j_zero;

  assign w_i_zero = (i_cur_i == '0);
  assign w_j_zero = (i_cur_j == '0);

  always_comb begin
    o_next_i  = i_cur_i;
    o_next_j  = i_cur_j;
    o_illegal = 1'b0;
    // The origin is the terminal cell, so its stored code is never interpreted.
    if (!(w_i_zero && w_j_zero)) begin
      case (i_code)
        PATH_DIAG: begin
          if (w_i_zero || w_j_zero) begin
            o_illegal = 1'b1;
          end else begin
            o_next_i = i_cur_i - ONE;
            o_next_j = i_cur_j - ONE;
          end
        end
        PATH_UP: begin
          if (w_i_zero) o_illegal = 1'b1;
          else          o_next_i  = i_cur_i - ONE;
        end
        PATH_LEFT: begin
          if (w_j_zero) o_illegal = 1'b1;
          else          o_next_j  = i_cur_j - ONE;
        end
        default: o_illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/dtw_traceback.sv
// DTW traceback: walks the path-direction RAM from (last_i, last_j) back to the
// origin and streams coordinates over valid/ready. Optional o_len via DTW_TB_LEN_EN.
module dtw_traceback #(
  parameter int IDX_W  = dtw_pkg::IDX_W,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic [IDX_W-1:0]  i_last_i,
  input  logic [IDX_W-1:0]  i_last_j,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [1:0]        mem_rdata,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [IDX_W-1:0]  o_i,
  output logic [IDX_W-1:0]  o_j,
  output logic              o_last,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef DTW_TB_LEN_EN
  ,
  output logic [CNT_W-1:0]  o_len
`endif
);
  import dtw_pkg::*;

  dtw_state_e       r_state;
  logic [IDX_W-1:0] r_cur_i;
  logic [IDX_W-1:0] r_cur_j;
  logic [1:0]       r_code;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_bound;
  logic             r_mem_ren;
  logic             r_valid;
  logic             r_last;
  logic             r_done;
  logic             r_err;

  logic [1:0]       w_step_code;
  logic [IDX_W-1:0] w_next_i;
  logic [IDX_W-1:0] w_next_j;
  logic             w_illegal;
  logic             w_origin;
  logic [CNT_W-1:0] w_cnt_inc;

  // The freshly returned code is checked in WAIT; the held copy drives the move in EMIT.
  assign w_step_code = (r_state == S_WAIT) ? mem_rdata : r_code;
  assign w_origin    = (r_cur_i == '0) && (r_cur_j == '0);
  assign w_cnt_inc   = r_cnt + CNT_W'(1);

  dtw_tb_step #(.IDX_W(IDX_W)) u_step (
    .i_code    (w_step_code),
    .i_cur_i   (r_cur_i),
    .i_cur_j   (r_cur_j),
    .o_next_i  (w_next_i),
    .o_next_j  (w_next_j),
    .o_illegal (w_illegal)
  );

`ifdef DTW_TB_LEN_EN
  logic [CNT_W-1:0] r_len;
  assign o_len = r_len;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= S_IDLE;
      r_cur_i   <= '0;
      r_cur_j   <= '0;
      r_code    <= PATH_RST;
      r_cnt     <= '0;
      r_bound   <= '0;
      r_mem_ren <= 1'b0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
`ifdef DTW_TB_LEN_EN
      r_len     <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cur_i   <= i_last_i;
            r_cur_j   <= i_last_j;
            r_err     <= 1'b0;
            r_cnt     <= '0;
            r_bound   <= CNT_W'(i_last_i) + CNT_W'(i_last_j) + CNT_W'(1);
            r_mem_ren <= 1'b1;
            r_state   <= S_READ;
          end
        end
        S_READ: begin
          r_mem_ren <= 1'b0;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          r_code <= mem_rdata;
          if (w_illegal) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_FIN;
`ifdef DTW_TB_LEN_EN
            r_len   <= r_cnt;
`endif
          end else begin
            r_valid <= 1'b1;
            r_last  <= w_origin;
            r_state <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (i_ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_cnt   <= w_cnt_inc;
            if (r_last || (w_cnt_inc >= r_bound)) begin
              // Reaching the bound without the origin means the path loops or is corrupt.
              r_err   <= r_err | ~r_last;
              r_done  <= 1'b1;
              r_state <= S_FIN;
`ifdef DTW_TB_LEN_EN
              r_len   <= w_cnt_inc;
`endif
            end else begin
              r_cur_i   <= w_next_i;
              r_cur_j   <= w_next_j;
              r_mem_ren <= 1'b1;
              r_state   <= S_READ;
            end
          end
        end
        S_FIN: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_ren   = r_mem_ren;
  assign mem_raddr = {r_cur_i, r_cur_j};
  assign o_valid   = r_valid;
  assign o_i       = r_cur_i;
  assign o_j       = r_cur_j;
  assign o_last    = r_last;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_dtw_traceback.sv
// Directed bench for dtw_traceback: path RAM model, handshake/read monitor and
// hand-computed coordinate sequences. Checks o_len when DTW_TB_LEN_EN is defined.
`timescale 1ns/1ps
module tb_dtw_traceback;

  localparam int IDX_W  = 5;
  localparam int ADDR_W = 10;
  localparam int CNT_W  = 6;

  logic              clk;
  logic              nrst;
  logic              start;
  logic [IDX_W-1:0]  i_last_i;
  logic [IDX_W-1:0]  i_last_j;
  logic              mem_ren;
  logic [ADDR_W-1:0] mem_raddr;
  logic [1:0]        mem_rdata;
  logic              o_valid;
  logic              i_ready;
  logic [IDX_W-1:0]  o_i;
  logic [IDX_W-1:0]  o_j;
  logic              o_last;
  logic              busy;
  logic              done;
  logic              err;
`ifdef DTW_TB_LEN_EN
  logic [CNT_W-1:0]  o_len;
`endif

  dtw_traceback #(.IDX_W(IDX_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .start     (start),
    .i_last_i  (i_last_i),
    .i_last_j  (i_last_j),
    .mem_ren   (mem_ren),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_i       (o_i),
    .o_j       (o_j),
    .o_last    (o_last),
    .busy      (busy),
    .done      (done),
    .err       (err)
`ifdef DTW_TB_LEN_EN
    ,
    .o_len     (o_len)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= mem[mem_raddr];
  end

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;
  int q_i[$], q_j[$], q_last[$], q_addr[$];
  int e_i[$], e_j[$], e_last[$], e_addr[$];

  always @(negedge clk) begin
    if (nrst) begin
      if (o_valid && i_ready) begin
        q_i.push_back(int'(o_i));
        q_j.push_back(int'(o_j));
        q_last.push_back(int'(o_last));
      end
      if (mem_ren) q_addr.push_back(int'(mem_raddr));
      if (done) n_done++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int addr_of(input int i, input int j);
    return (i << IDX_W) | j;
  endfunction

  task automatic clear_mem();
    for (int k = 0; k < (1<<ADDR_W); k++) mem[k] = 2'b00;
  endtask

  task automatic start_walk(input int li, input int lj);
    q_i.delete(); q_j.delete(); q_last.delete(); q_addr.delete();
    i_last_i = IDX_W'(li);
    i_last_j = IDX_W'(lj);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int base;
    base = n_done;
    for (int k = 0; k < budget && n_done == base; k++) begin
      @(posedge clk); #1;
    end
    check({tag, " done pulses"}, n_done - base, 1);
    @(posedge clk); #1;
    check({tag, " busy after"}, busy, 0);
  endtask

  task automatic check_seq(input string tag, input int exp_err);
    check({tag, " n_coords"}, q_i.size(), e_i.size());
    for (int k = 0; k < q_i.size() && k < e_i.size(); k++) begin
      check($sformatf("%s i[%0d]", tag, k), q_i[k], e_i[k]);
      check($sformatf("%s j[%0d]", tag, k), q_j[k], e_j[k]);
      check($sformatf("%s last[%0d]", tag, k), q_last[k], e_last[k]);
    end
    check({tag, " n_reads"}, q_addr.size(), e_addr.size());
    for (int k = 0; k < q_addr.size() && k < e_addr.size(); k++)
      check($sformatf("%s addr[%0d]", tag, k), q_addr[k], e_addr[k]);
    check({tag, " err"}, err, exp_err);
`ifdef DTW_TB_LEN_EN
    check({tag, " o_len"}, o_len, e_i.size());
`endif
  endtask

  task automatic set_exp_diag3();
    e_i = '{2, 1, 0}; e_j = '{2, 1, 0}; e_last = '{0, 0, 1};
    e_addr = '{addr_of(2,2), addr_of(1,1), 0};
  endtask

  task automatic load_diag3();
    clear_mem();
    for (int a = 0; a < 3; a++)
      for (int b = 0; b < 3; b++) mem[addr_of(a,b)] = 2'b11;
  endtask

  initial begin
    bit found;
    nrst = 1'b0; start = 1'b0; i_ready = 1'b1;
    i_last_i = '0; i_last_j = '0;
    clear_mem();
    #12;
    check("rst o_valid", o_valid, 0);
    check("rst mem_ren", mem_ren, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst err", err, 0);
    check("rst o_last", o_last, 0);
    check("rst coord", {o_i, o_j}, 0);
    @(posedge clk); #1;
    nrst = 1'b1;
    @(posedge clk); #1;

    // 3x3 diagonal with latency checks
    load_diag3();
    start_walk(2, 2);
    check("diag ren cycle1", mem_ren, 1);
    check("diag raddr cycle1", mem_raddr, addr_of(2,2));
    check("diag busy", busy, 1);
    @(posedge clk); #1;
    check("diag ren cycle2", mem_ren, 0);
    @(posedge clk); #1;
    check("diag valid cycle3", o_valid, 1);
    wait_done("diag", 50);
    set_exp_diag3();
    check_seq("diag", 0);

    // single row walking left; origin code left as 00
    clear_mem();
    for (int b = 1; b < 4; b++) mem[addr_of(0,b)] = 2'b01;
    start_walk(0, 3);
    wait_done("row", 50);
    e_i = '{0, 0, 0, 0}; e_j = '{3, 2, 1, 0}; e_last = '{0, 0, 0, 1};
    e_addr = '{3, 2, 1, 0};
    check_seq("row", 0);

    // mixed path with a downstream stall at (1,1)
    clear_mem();
    mem[addr_of(2,1)] = 2'b10;
    mem[addr_of(1,1)] = 2'b01;
    mem[addr_of(1,0)] = 2'b10;
    start_walk(2, 1);
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      if (o_valid && o_i == 1 && o_j == 1) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("mixed reach (1,1)", found, 1);
    i_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("stall valid %0d", k), o_valid, 1);
      check($sformatf("stall coord %0d", k), {o_i, o_j}, {5'd1, 5'd1});
      check($sformatf("stall ren %0d", k), mem_ren, 0);
    end
    i_ready = 1'b1;
    wait_done("mixed", 50);
    e_i = '{2, 1, 1, 0}; e_j = '{1, 1, 0, 0}; e_last = '{0, 0, 0, 1};
    e_addr = '{addr_of(2,1), addr_of(1,1), addr_of(1,0), 0};
    check_seq("mixed", 0);

    // corrupt entry mid-path
    clear_mem();
    mem[addr_of(2,2)] = 2'b11;
    mem[addr_of(1,1)] = 2'b00;
    start_walk(2, 2);
    wait_done("corrupt", 50);
    e_i = '{2}; e_j = '{2}; e_last = '{0};
    e_addr = '{addr_of(2,2), addr_of(1,1)};
    check_seq("corrupt", 1);

    // diagonal off the top edge at the very first cell
    clear_mem();
    mem[addr_of(0,2)] = 2'b11;
    start_walk(0, 2);
    wait_done("edge", 50);
    e_i.delete(); e_j.delete(); e_last.delete();
    e_addr = '{addr_of(0,2)};
    check_seq("edge", 1);

    // 1x1 grid; its start must also clear the sticky err
    start_walk(0, 0);
    check("1x1 err cleared", err, 0);
    wait_done("1x1", 50);
    e_i = '{0}; e_j = '{0}; e_last = '{1}; e_addr = '{0};
    check_seq("1x1", 0);

    // start pulse in the middle of a walk is ignored
    load_diag3();
    mem[addr_of(1,2)] = 2'b01;
    start_walk(2, 2);
    repeat (4) begin @(posedge clk); #1; end
    i_last_i = 5'd1; i_last_j = 5'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("restart", 50);
    set_exp_diag3();
    check_seq("restart", 0);

    // asynchronous reset while a coordinate is being offered
    i_ready = 1'b0;
    start_walk(2, 2);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (o_valid) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("pre-reset valid", o_valid, 1);
    #2 nrst = 1'b0;
    #1;
    check("async rst valid", o_valid, 0);
    check("async rst busy", busy, 0);
    check("async rst ren", mem_ren, 0);
    @(posedge clk); #1;
    nrst = 1'b1;
    i_ready = 1'b1;
    @(posedge clk); #1;
    start_walk(2, 2);
    wait_done("post-reset", 50);
    set_exp_diag3();
    check_seq("post-reset", 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
